// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: datapath width, FSM state
// encodings, the canonical NOP and the sequential PC step.
`timescale 1ns/1ps

package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  // FSM state encodings (plain constants so legacy code can share them).
  localparam logic [2:0] FS_BOOT  = 3'd0;
  localparam logic [2:0] FS_REQ   = 3'd1;
  localparam logic [2:0] FS_WAIT  = 3'd2;
  localparam logic [2:0] FS_HOLD  = 3'd3;
  localparam logic [2:0] FS_DRAIN = 3'd4;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer for the RV32I core. Owns the architectural PC, keeps one
// fetch outstanding to instruction memory and presents fetched instructions
// through a one-entry buffer to decode. A taken jump redirects the PC,
// squashes the buffered instruction and discards any in-flight response.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to redirect misaligned
// jump targets to TRAP_VECTOR and report them on trap_valid/trap_tval.
// Without it the trap ports and TRAP_VECTOR do not exist and targets are
// forced to word alignment.
`timescale 1ns/1ps

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction memory request/response
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  // decode-side buffer
  output logic            if_valid,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  // redirect from execute
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  output logic            flush
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_tval
`endif
);

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic            load;          // response captured into the buffer this cycle
  logic            jump_taken;    // jumps are ignored while still booting
  logic            consume;       // decode takes the buffered instruction
  logic            outstanding;   // a response will still arrive after this cycle
  logic [XLEN-1:0] redirect_pc;

  assign jump_taken = jump_flag && (state != FS_BOOT);
  assign consume    = if_valid && id_ready;

  // A request is still in flight past this cycle if we are waiting (or already
  // draining) and the response is not here yet, or if imem accepts one now.
  // Responses have latency >= 1, so none can arrive in the accepting cycle.
  assign outstanding = (((state == FS_WAIT) || (state == FS_DRAIN)) && !imem_rsp_valid)
                     || ((state == FS_REQ) && imem_req_ready);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;

  // Misaligned targets go to the trap vector and are reported for one cycle.
  always_comb begin
    misaligned  = (jump_target[1:0] != 2'b00);
    redirect_pc = misaligned ? TRAP_VECTOR : jump_target;
    trap_valid  = jump_taken && misaligned;
    trap_tval   = (jump_taken && misaligned) ? jump_target : '0;
  end
`else
  // Without trap support the low target bits are simply discarded.
  assign redirect_pc = jump_target & PC_ALIGN_MASK;
`endif

  // Next-state and next-PC selection; a jump overrides every other event.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    if (jump_taken) begin
      pc_nxt    = redirect_pc;
      state_nxt = outstanding ? FS_DRAIN : FS_REQ;
    end else begin
      case (state)
        FS_BOOT: state_nxt = FS_REQ;
        FS_REQ: begin
          if (imem_req_ready) state_nxt = FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rsp_valid) begin
            load      = 1'b1;
            pc_nxt    = pc_inc(pc);
            state_nxt = consume ? FS_REQ : FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (id_ready) state_nxt = FS_REQ;
        end
        FS_DRAIN: begin
          if (imem_rsp_valid) state_nxt = FS_REQ;
        end
        default: state_nxt = FS_BOOT;
      endcase
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_BOOT;
      pc    <= RESET_VECTOR;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // One-entry instruction buffer: squashed by a jump, refilled by a response,
  // emptied when decode consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
    end else if (jump_taken) begin
      if_valid <= 1'b0;
    end else if (load) begin
      if_valid <= 1'b1;
      if_inst  <= imem_rsp_data;
      if_pc    <= pc;
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

  assign imem_req_valid = (state == FS_REQ);
  assign imem_addr      = (state == FS_REQ) ? pc : '0;
  assign flush          = jump_taken;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each scenario task drives the imem,
// decode and jump inputs cycle by cycle and compares outputs against
// hand-derived values. Build with FETCH_MISALIGN_TRAP_EN defined to cover
// the trap variant.
`timescale 1ns/1ps

module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [31:0]     imem_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            if_valid;
  logic [31:0]     if_inst;
  logic [31:0]     if_pc;
  logic            id_ready = 1'b0;
  logic            jump_flag = 1'b0;
  logic [31:0]     jump_target = '0;
  logic            flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            trap_valid;
  logic [31:0]     trap_tval;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .jump_flag      (jump_flag),
    .jump_target    (jump_target),
    .flush          (flush)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .trap_valid     (trap_valid),
    .trap_tval      (trap_tval)
`endif
  );

  always #5 clk = ~clk;

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0013;
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with all inputs idle; returns in REQ one cycle after release.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    id_ready       = 1'b0;
    jump_flag      = 1'b0;
    jump_target    = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL boot_req: valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_fill: if_valid=%b expected 1", if_valid);
    end
    // Assert reset mid-cycle; the buffer must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: if_valid=%b req_valid=%b expected 0 0", if_valid, imem_req_valid);
    end
    jump_flag   = 1'b1;
    jump_target = 32'h0000_0040;
    tick();
    tick();
    checks++;
    if ({imem_req_valid, if_valid, flush, imem_addr, if_inst, if_pc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b ifv=%b flush=%b addr=%h inst=%h pc=%h expected all 0",
               imem_req_valid, if_valid, flush, imem_addr, if_inst, if_pc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL boot_ignores_jump: flush=%b expected 0", flush);
    end
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL boot_addr: valid=%b addr=%h expected valid=1 addr=00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] exp_addr;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr       = 32'(i * 4);
      imem_req_ready = 1'b1;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr || flush !== 1'b0) begin
        failures++;
        $display("FAIL fetch_req[%0d]: valid=%b addr=%h flush=%b expected 1 %h 0",
                 i, imem_req_valid, imem_addr, flush, exp_addr);
      end
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(exp_addr);
      #1;
      checks++;
      if (imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL fetch_wait[%0d]: req_valid=%b expected 0", i, imem_req_valid);
      end
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_addr || if_inst !== inst_of(exp_addr)) begin
        failures++;
        $display("FAIL fetch_buf[%0d]: valid=%b pc=%h inst=%h expected 1 %h %h",
                 i, if_valid, if_pc, if_inst, exp_addr, inst_of(exp_addr));
      end
      tick();
    end
  endtask

  task automatic test_hold();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b1 || if_inst !== inst_of(32'h0)) begin
        failures++;
        $display("FAIL hold[%0d]: req_valid=%b if_valid=%b inst=%h expected 0 1 %h",
                 i, imem_req_valid, if_valid, if_inst, inst_of(32'h0));
      end
      tick();
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_resume: req_valid=%b addr=%h if_valid=%b expected 1 00000004 0",
               imem_req_valid, imem_addr, if_valid);
    end
  endtask

  task automatic test_jump_wait();
    do_reset();
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    jump_flag      = 1'b1;
    jump_target    = 32'h0000_0200;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL jw_flush: flush=%b expected 1", flush);
    end
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL jw_drain: flush=%b req_valid=%b if_valid=%b expected 0 0 0",
               flush, imem_req_valid, if_valid);
    end
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = INST_NOP;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL jw_refetch: if_valid=%b req_valid=%b addr=%h expected 0 1 00000200",
               if_valid, imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h200);
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== inst_of(32'h200)) begin
      failures++;
      $display("FAIL jw_target_inst: valid=%b pc=%h inst=%h expected 1 00000200 %h",
               if_valid, if_pc, if_inst, inst_of(32'h200));
    end
    id_ready = 1'b0;
  endtask

  task automatic test_jump_rsp();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h0);
    jump_flag      = 1'b1;
    jump_target    = 32'h0000_0200;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL jr_flush: flush=%b expected 1", flush);
    end
    tick();
    imem_rsp_valid = 1'b0;
    jump_flag      = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL jr_no_drain: req_valid=%b addr=%h if_valid=%b expected 1 00000200 0",
               imem_req_valid, imem_addr, if_valid);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h200);
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      failures++;
      $display("FAIL jr_next_rsp_kept: valid=%b pc=%h expected 1 00000200", if_valid, if_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem_req_ready = 1'b1;
    jump_flag      = 1'b1;
    jump_target    = 32'h0000_0080;
    #1;
    checks++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: flush=%b req_valid=%b expected 1 1", flush, imem_req_valid);
    end
    tick();
    imem_req_ready = 1'b0;
    jump_target    = 32'h0000_0090;
    #1;
    checks++;
    if (flush !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: flush=%b req_valid=%b expected 1 0", flush, imem_req_valid);
    end
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_still_drain: req_valid=%b expected 0", imem_req_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = INST_NOP;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h90 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_latest_wins: req_valid=%b addr=%h if_valid=%b expected 1 00000090 0",
               imem_req_valid, imem_addr, if_valid);
    end
  endtask

  task automatic test_self_redirect();
    do_reset();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    jump_flag      = 1'b1;
    jump_target    = 32'h0000_0004;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL self_flush: flush=%b expected 1", flush);
    end
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL self_refetch: if_valid=%b req_valid=%b addr=%h expected 0 1 00000004",
               if_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_flag   = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_top: req_valid=%b addr=%h expected 1 fffffffc", imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = inst_of(32'hFFFF_FFFC);
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_buf: valid=%b pc=%h expected 1 fffffffc", if_valid, if_pc);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: req_valid=%b addr=%h expected 1 00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    jump_flag   = 1'b1;
    jump_target = 32'h0000_0202;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      failures++;
      $display("FAIL mis_flush: flush=%b expected 1", flush);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++;
    if (trap_valid !== 1'b1 || trap_tval !== 32'h0000_0202) begin
      failures++;
      $display("FAIL mis_trap: trap_valid=%b tval=%h expected 1 00000202", trap_valid, trap_tval);
    end
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (trap_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL mis_vector: trap_valid=%b req_valid=%b addr=%h expected 0 1 00000100",
               trap_valid, imem_req_valid, imem_addr);
    end
    jump_flag   = 1'b1;
    jump_target = 32'h0000_0040;
    #1;
    checks++;
    if (trap_valid !== 1'b0 || flush !== 1'b1) begin
      failures++;
      $display("FAIL aligned_no_trap: trap_valid=%b flush=%b expected 0 1", trap_valid, flush);
    end
    tick();
    jump_flag = 1'b0;
`else
    tick();
    jump_flag = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL mis_aligned_addr: req_valid=%b addr=%h expected 1 00000200", imem_req_valid, imem_addr);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_jump_wait();
    test_jump_rsp();
    test_back_to_back();
    test_self_redirect();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
